// File: rtl/cache_repl_mt_gen.sv
// Per-set LRU victim selector with per-way valid tracking and a runtime choice
// between shared ways and ways partitioned per hardware thread.
module cache_repl_mt_gen #(
  parameter  int NUM_SET     = 64,
  parameter  int WAYS        = 8,
  parameter  int NUM_THREADS = 2,
  localparam int SET_W       = $clog2(NUM_SET),
  localparam int WAY_W       = $clog2(WAYS),
  localparam int THR_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int WPT         = WAYS / NUM_THREADS
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             part_mode_i,
  input  logic             victim_req_i,
  input  logic [SET_W-1:0] victim_set_i,
  input  logic [THR_W-1:0] victim_thr_i,
  output logic             victim_valid_o,
  output logic [WAY_W-1:0] victim_way_o,
  output logic             victim_inv_o,
  input  logic             touch_req_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             fill_req_i,
  input  logic [SET_W-1:0] fill_set_i,
  input  logic [WAY_W-1:0] fill_way_i,
  input  logic             inv_req_i,
  input  logic [SET_W-1:0] inv_set_i,
  input  logic [WAY_W-1:0] inv_way_i
);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

  // Ages form a permutation 0..n-1 inside every domain; this is the starting one.
  function automatic age_vec_t init_ages(input logic part);
    age_vec_t r;
    for (int i = 0; i < WAYS; i++) begin
      r[i] = part ? WAY_W'(i % WPT) : WAY_W'(i);
    end
    return r;
  endfunction

  // Make way w the MRU of its domain; younger ways in that domain age by one.
  function automatic age_vec_t bump(input age_vec_t a, input logic [WAY_W-1:0] w,
                                    input logic part);
    age_vec_t r;
    r = a;
    for (int i = 0; i < WAYS; i++) begin
      if ((!part || (i / WPT) == (int'(w) / WPT)) && (a[i] < a[w])) begin
        r[i] = a[i] + WAY_W'(1);
      end
    end
    r[w] = '0;
    return r;
  endfunction

  age_vec_t        age_q   [NUM_SET];
  age_vec_t        age_d   [NUM_SET];
  logic [WAYS-1:0] valid_q [NUM_SET];
  logic [WAYS-1:0] valid_d [NUM_SET];
  logic            part_q;
  logic            mode_chg;

  logic             victim_valid_q;
  logic [WAY_W-1:0] victim_way_q;
  logic             victim_inv_q;

  assign mode_chg = (part_mode_i != part_q);

  // Order within a set: touch, then fill, then invalidate.
  always_comb begin
    for (int s = 0; s < NUM_SET; s++) begin
      age_d[s]   = age_q[s];
      valid_d[s] = valid_q[s];
      if (mode_chg) begin
        age_d[s] = init_ages(part_mode_i);
      end else begin
        if (touch_req_i && (touch_set_i == SET_W'(s))) begin
          age_d[s] = bump(age_d[s], touch_way_i, part_q);
        end
        if (fill_req_i && (fill_set_i == SET_W'(s))) begin
          age_d[s]               = bump(age_d[s], fill_way_i, part_q);
          valid_d[s][fill_way_i] = 1'b1;
        end
        if (inv_req_i && (inv_set_i == SET_W'(s))) begin
          valid_d[s][inv_way_i] = 1'b0;
        end
      end
    end
  end

  age_vec_t         sel_age;
  logic [WAYS-1:0]  sel_valid;
  logic             found_inv;
  logic [WAY_W-1:0] inv_pick;
  logic [WAY_W-1:0] max_pick;
  logic [WAY_W-1:0] max_age;
  int               dom_lo;
  int               dom_hi;

  // Search the registered state only; the lowest invalid way beats the oldest way.
  always_comb begin
    sel_age   = age_q[victim_set_i];
    sel_valid = valid_q[victim_set_i];
    found_inv = 1'b0;
    inv_pick  = '0;
    max_pick  = '0;
    max_age   = '0;
    dom_lo    = part_q ? int'(victim_thr_i) * WPT : 0;
    dom_hi    = part_q ? dom_lo + WPT : WAYS;
    for (int i = 0; i < WAYS; i++) begin
      if (i >= dom_lo && i < dom_hi) begin
        if (!sel_valid[i] && !found_inv) begin
          found_inv = 1'b1;
          inv_pick  = WAY_W'(i);
        end
        if (sel_age[i] >= max_age) begin
          max_age  = sel_age[i];
          max_pick = WAY_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int s = 0; s < NUM_SET; s++) begin
        age_q[s]   <= init_ages(part_mode_i);
        valid_q[s] <= '0;
      end
      part_q         <= part_mode_i;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_inv_q   <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SET; s++) begin
        age_q[s]   <= age_d[s];
        valid_q[s] <= valid_d[s];
      end
      part_q         <= part_mode_i;
      victim_valid_q <= victim_req_i;
      if (victim_req_i) begin
        victim_way_q <= found_inv ? inv_pick : max_pick;
        victim_inv_q <= found_inv;
      end
    end
  end

  assign victim_valid_o = victim_valid_q;
  assign victim_way_o   = victim_way_q;
  assign victim_inv_o   = victim_inv_q;

endmodule

// File: tb/tb_cache_repl_mt_gen.sv
// Directed bench for cache_repl_mt_gen (64 sets, 8 ways, 2 threads) with
// hand-computed victim expectations.
module tb_cache_repl_mt_gen;

  localparam int NUM_SET     = 64;
  localparam int WAYS        = 8;
  localparam int NUM_THREADS = 2;
  localparam int SET_W       = 6;
  localparam int WAY_W       = 3;
  localparam int THR_W       = 1;

  logic             clock;
  logic             reset_n;
  logic             part_mode;
  logic             victim_req;
  logic [SET_W-1:0] victim_set;
  logic [THR_W-1:0] victim_thr;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             victim_inv;
  logic             touch_req;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             fill_req;
  logic [SET_W-1:0] fill_set;
  logic [WAY_W-1:0] fill_way;
  logic             inv_req;
  logic [SET_W-1:0] inv_set;
  logic [WAY_W-1:0] inv_way;

  int testCount = 0;
  int failCount = 0;

  cache_repl_mt_gen #(
    .NUM_SET(NUM_SET), .WAYS(WAYS), .NUM_THREADS(NUM_THREADS)
  ) dut (
    .clock_i(clock), .reset_ni(reset_n), .part_mode_i(part_mode),
    .victim_req_i(victim_req), .victim_set_i(victim_set), .victim_thr_i(victim_thr),
    .victim_valid_o(victim_valid), .victim_way_o(victim_way), .victim_inv_o(victim_inv),
    .touch_req_i(touch_req), .touch_set_i(touch_set), .touch_way_i(touch_way),
    .fill_req_i(fill_req), .fill_set_i(fill_set), .fill_way_i(fill_way),
    .inv_req_i(inv_req), .inv_set_i(inv_set), .inv_way_i(inv_way)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (victim_req && int'(victim_thr) >= NUM_THREADS) $error("[TB] illegal victim_thr");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample point is 1ns after the edge, single-cycle requests drop.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    victim_req = 1'b0;
    touch_req  = 1'b0;
    fill_req   = 1'b0;
    inv_req    = 1'b0;
  endtask

  task automatic doTouch(input int s, input int w);
    touch_req = 1'b1; touch_set = SET_W'(s); touch_way = WAY_W'(w);
    applyStimulus();
  endtask

  task automatic doFill(input int s, input int w);
    fill_req = 1'b1; fill_set = SET_W'(s); fill_way = WAY_W'(w);
    applyStimulus();
  endtask

  task automatic doInv(input int s, input int w);
    inv_req = 1'b1; inv_set = SET_W'(s); inv_way = WAY_W'(w);
    applyStimulus();
  endtask

  task automatic lookup(input string tag, input int s, input int thr,
                        input int expWay, input int expInv);
    victim_req = 1'b1; victim_set = SET_W'(s); victim_thr = THR_W'(thr);
    applyStimulus();
    checkOutput({tag, ".vld"}, 32'(victim_valid), 32'd1);
    checkOutput({tag, ".way"}, 32'(victim_way), 32'(expWay));
    checkOutput({tag, ".inv"}, 32'(victim_inv), 32'(expInv));
  endtask

  int touchSeq [7] = '{0, 1, 3, 4, 5, 7, 2};
  int victSeq  [7] = '{1, 3, 4, 5, 7, 2, 6};

  initial begin
    reset_n = 1'b0; part_mode = 1'b0;
    victim_req = 1'b0; victim_set = '0; victim_thr = '0;
    touch_req = 1'b0; touch_set = '0; touch_way = '0;
    fill_req = 1'b0; fill_set = '0; fill_way = '0;
    inv_req = 1'b0; inv_set = '0; inv_way = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst.vld", 32'(victim_valid), 32'd0);
    checkOutput("rst.way", 32'(victim_way), 32'd0);
    checkOutput("rst.inv", 32'(victim_inv), 32'd0);
    reset_n = 1'b1;

    // Shared mode: empty set, then filled in order so way 0 is LRU.
    lookup("t1.empty", 3, 0, 0, 1);
    for (int w = 0; w < 8; w++) doFill(3, w);
    lookup("t1.full", 3, 0, 0, 0);
    applyStimulus();
    checkOutput("t1.idle", 32'(victim_valid), 32'd0);

    doTouch(3, 0);
    lookup("t2.touch0", 3, 0, 1, 0);
    for (int w = 1; w < 8; w++) doTouch(3, w);
    lookup("t2.touchAll", 3, 0, 0, 0);

    // Partitioned: two domains of four ways each.
    part_mode = 1'b1;
    applyStimulus();
    for (int w = 0; w < 8; w++) doFill(5, w);
    lookup("t3.thr1", 5, 1, 4, 0);
    lookup("t3.thr0", 5, 0, 0, 0);
    doTouch(5, 4);
    lookup("t3.thr1b", 5, 1, 5, 0);
    lookup("t3.thr0b", 5, 0, 0, 0);
    lookup("t3.reload0", 3, 0, 3, 0);
    lookup("t3.reload1", 3, 1, 7, 0);

    // Shared again: same-cycle touch way2 + fill way6 leaves way6 MRU, way2 next.
    part_mode = 1'b0;
    applyStimulus();
    for (int w = 0; w < 8; w++) doFill(1, w);
    touch_req = 1'b1; touch_set = 6'd1; touch_way = 3'd2;
    fill_req  = 1'b1; fill_set  = 6'd1; fill_way  = 3'd6;
    applyStimulus();
    lookup("t4.combo", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      doTouch(1, touchSeq[i]);
      lookup($sformatf("t4.order%0d", i), 1, 0, victSeq[i], 0);
    end
    doInv(1, 3);
    lookup("t4.inv", 1, 0, 3, 1);
    fill_req = 1'b1; fill_set = 6'd1; fill_way = 3'd3;
    inv_req  = 1'b1; inv_set  = 6'd1; inv_way  = 3'd3;
    applyStimulus();
    lookup("t4.fillInv", 1, 0, 3, 1);

    // Lookup sees pre-touch ages; back-to-back requests both answer.
    for (int w = 0; w < 8; w++) doFill(7, w);
    victim_req = 1'b1; victim_set = 6'd7; victim_thr = 1'b0;
    touch_req  = 1'b1; touch_set  = 6'd7; touch_way  = 3'd0;
    applyStimulus();
    checkOutput("t5.first.vld", 32'(victim_valid), 32'd1);
    checkOutput("t5.first.way", 32'(victim_way), 32'd0);
    victim_req = 1'b1; victim_set = 6'd7; victim_thr = 1'b0;
    applyStimulus();
    checkOutput("t5.second.vld", 32'(victim_valid), 32'd1);
    checkOutput("t5.second.way", 32'(victim_way), 32'd1);
    applyStimulus();
    checkOutput("t5.idle", 32'(victim_valid), 32'd0);

    // Mode toggle drops the same-cycle fill, keeps valids, reloads ages.
    part_mode = 1'b1;
    fill_req = 1'b1; fill_set = 6'd9; fill_way = 3'd0;
    applyStimulus();
    lookup("t6.dropped", 9, 0, 0, 1);
    lookup("t6.keep0", 7, 0, 3, 0);
    lookup("t6.keep1", 7, 1, 7, 0);

    victim_req = 1'b1; victim_set = 6'd7; victim_thr = 1'b0;
    applyStimulus();
    checkOutput("t6.preRst.vld", 32'(victim_valid), 32'd1);
    victim_req = 1'b1; reset_n = 1'b0;
    applyStimulus();
    checkOutput("t6.rst.vld", 32'(victim_valid), 32'd0);
    applyStimulus();
    reset_n = 1'b1;
    lookup("t6.post0", 7, 0, 0, 1);
    lookup("t6.post1", 3, 1, 4, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
